grn_node_multi: RTL and testbench
=================================

GRN_NODE_MULTI -- requirements
Module: grn_node_multi

Interface
REQ-001 Parameter NCH, default 2, number of independent state channels (1..16).
REQ-002 Parameter NIN, default 2, number of regulator inputs per channel (1..8).
REQ-003 Parameter DIV_W, default 4, width of the per-channel update divider.
REQ-004 Parameter FUNC, default 0, combine function: 0 = OR, 1 = AND, 2 = majority (ties resolve to 1).
REQ-005 Parameter CNT_W, default 8, transition-counter width.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 reset_nos  in  1  synchronous network re-initialise.
REQ-009 init_state  in  1  value loaded into every channel on reset_nos.
REQ-010 start  in  NCH  per-channel evaluation strobe.
REQ-011 div  in  NCH*DIV_W  per-channel divider; channel c updates on every (div[c]+1)-th start[c].
REQ-012 din  in  NCH*NIN  regulator inputs; channel c uses bits [c*NIN +: NIN].
REQ-013 s  out  NCH  registered node state per channel.
REQ-014 upd  out  NCH  one-cycle pulse, channel state written this cycle.
REQ-015 chg  out  NCH  one-cycle pulse, channel state changed value this cycle.
REQ-016 tcnt  out  NCH*CNT_W  per-channel transition count (present only with GRN_NODE_TCNT_EN).

Function
REQ-017 Each channel SHALL hold s[c] and a DIV_W-bit phase counter ph[c].
REQ-018 Priority per cycle SHALL be: rst_n low > reset_nos > start[c] > hold.
REQ-019 On reset_nos, every channel SHALL load s = init_state and ph = 0, with upd = 1 and chg = 0.
REQ-020 On start[c] with ph[c] == 0, s[c] SHALL take the combine value and ph[c] SHALL reload div[c]; upd[c] = 1.
REQ-021 On start[c] with ph[c] != 0, ph[c] SHALL decrement and s[c] SHALL hold; upd[c] = 0.
REQ-022 The combine value is FUNC applied over the NIN bits of channel c, sampled in the same cycle as start[c].
REQ-023 With div[c] = 0, s[c] SHALL update on every start[c]; with div[c] = 1, the update pattern is update, skip, update, ...
REQ-024 A change to div[c] SHALL take effect only at the next reload; it SHALL NOT affect a countdown in progress.
REQ-025 chg[c] SHALL be 1 only when upd[c] = 1 and the new s[c] differs from the old s[c].
REQ-026 upd and chg SHALL be registered and asserted in the cycle following the start edge, aligned with the new s.
REQ-027 Channels SHALL be fully independent; simultaneous starts on any subset SHALL be legal.
REQ-028 When reset_nos and start[c] are both high, reset_nos SHALL win and start[c] SHALL be ignored.

Reset
REQ-029 rst_n low SHALL asynchronously clear s, upd, chg and tcnt to 0 and set every ph to 1.
REQ-030 The first start[c] after rst_n deassertion is therefore a skip.
REQ-031 Deassertion SHALL be synchronised externally; the block adds no synchroniser.
REQ-032 rst_n asserted mid-countdown SHALL discard the phase without a residual upd or chg pulse.

Configuration
REQ-033 Macro GRN_NODE_TCNT_EN defined: each channel SHALL carry a CNT_W-bit counter that increments on chg[c], saturates at all-ones and clears on reset_nos.
REQ-034 Macro GRN_NODE_TCNT_EN undefined: the counters and the tcnt port SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Package grn_pkg SHALL hold the FUNC encodings (GRN_FUNC_OR, GRN_FUNC_AND, GRN_FUNC_MAJ) and the combine function.
REQ-036 The per-channel logic (state, phase, upd/chg, optional counter) SHALL be sub-module grn_node_ch, instantiated NCH times by generate.

Verification
REQ-037 reset_nos with init_state = 1, then din = 2'b00 with one start on channel 0, div = 0 -> s[0] = 0, upd[0] = 1, chg[0] = 1 one cycle later.
REQ-038 div[1] = 1, din = 2'b01 with FUNC = OR, four start[1] pulses after reset_nos -> updates on starts 1 and 3 only.
REQ-039 rst_n low then high, div = 0, one start -> no update (skip); second start -> update.
REQ-040 reset_nos and start[0] high in the same cycle -> s[0] = init_state and ph[0] = 0.
REQ-041 GRN_NODE_TCNT_EN, CNT_W = 2, alternating din, five toggles -> tcnt saturates at 3; reset_nos -> tcnt = 0.
REQ-042 FUNC = 2, NIN = 3, din = 3'b011 -> 1; din = 3'b001 -> 0.

Source files
------------

// File: rtl/grn_pkg.sv
// Shared definitions for the gene-regulatory node: combine-function encodings and the combine helper.
package grn_pkg;

    localparam int GRN_FUNC_OR  = 0;
    localparam int GRN_FUNC_AND = 1;
    localparam int GRN_FUNC_MAJ = 2;
    localparam int GRN_MAX_NIN  = 8;

    // Only the low n bits take part; majority ties resolve to 1.
    function automatic logic grn_combine(input logic [GRN_MAX_NIN-1:0] bits,
                                         input int n,
                                         input int func);
        logic any_one;
        logic all_one;
        int   ones;
        any_one = 1'b0;
        all_one = 1'b1;
        ones    = 0;
        for (int i = 0; i < GRN_MAX_NIN; i++) begin
            if (i < n) begin
                any_one = any_one | bits[i];
                all_one = all_one & bits[i];
                ones    = ones + int'(bits[i]);
            end
        end
        case (func)
            GRN_FUNC_AND: grn_combine = all_one;
            GRN_FUNC_MAJ: grn_combine = (2 * ones >= n);
            default:      grn_combine = any_one;
        endcase
    endfunction

endpackage

// File: rtl/grn_node_ch.sv
// One node channel: state bit, update divider phase, upd/chg pulses and, with
// GRN_NODE_TCNT_EN, a saturating transition counter.
module grn_node_ch
    import grn_pkg::*;
#(
    parameter int NIN   = 2,
    parameter int DIV_W = 4,
    parameter int FUNC  = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reset_nos,
    input  logic             init_state,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    input  logic [NIN-1:0]   din,
    output logic             s,
    output logic             upd,
    output logic             chg
`ifdef GRN_NODE_TCNT_EN
    ,
    output logic [CNT_W-1:0] tcnt
`endif
);

    logic [DIV_W-1:0]       ph;
    logic [GRN_MAX_NIN-1:0] din_ext;
    logic                   comb_v;
    logic                   load;
    logic                   flip;

    always_comb begin
        din_ext          = '0;
        din_ext[NIN-1:0] = din;
        comb_v           = grn_combine(din_ext, NIN, FUNC);
        load             = start && (ph == '0);
        flip             = load && (comb_v != s);
    end

    // Phase resets to 1 so the first start after power-up is a skip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s   <= 1'b0;
            ph  <= DIV_W'(1);
            upd <= 1'b0;
            chg <= 1'b0;
        end else if (reset_nos) begin
            s   <= init_state;
            ph  <= '0;
            upd <= 1'b1;
            chg <= 1'b0;
        end else if (load) begin
            s   <= comb_v;
            ph  <= div;
            upd <= 1'b1;
            chg <= flip;
        end else begin
            if (start) begin
                ph <= ph - DIV_W'(1);
            end
            upd <= 1'b0;
            chg <= 1'b0;
        end
    end

`ifdef GRN_NODE_TCNT_EN
    // Counts on the same edge that raises chg, so tcnt is aligned with the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
        end else if (reset_nos) begin
            tcnt <= '0;
        end else if (flip && (tcnt != '1)) begin
            tcnt <= tcnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/grn_node_multi.sv
// Multi-channel gene-regulatory node; optional per-channel transition counters
// are built when GRN_NODE_TCNT_EN is defined.
module grn_node_multi
    import grn_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int NIN   = 2,
    parameter int DIV_W = 4,
    parameter int FUNC  = 0,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reset_nos,
    input  logic                 init_state,
    input  logic [NCH-1:0]       start,
    input  logic [NCH*DIV_W-1:0] div,
    input  logic [NCH*NIN-1:0]   din,
    output logic [NCH-1:0]       s,
    output logic [NCH-1:0]       upd,
    output logic [NCH-1:0]       chg
`ifdef GRN_NODE_TCNT_EN
    ,
    output logic [NCH*CNT_W-1:0] tcnt
`endif
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        grn_node_ch #(
            .NIN   (NIN),
            .DIV_W (DIV_W),
            .FUNC  (FUNC),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .reset_nos  (reset_nos),
            .init_state (init_state),
            .start      (start[c]),
            .div        (div[c*DIV_W +: DIV_W]),
            .din        (din[c*NIN +: NIN]),
            .s          (s[c]),
            .upd        (upd[c]),
            .chg        (chg[c])
`ifdef GRN_NODE_TCNT_EN
            ,
            .tcnt       (tcnt[c*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_grn_node_multi.sv
// Directed scoreboard bench for grn_node_multi: OR-combine two-channel instance
// plus a 3-input majority instance.
module tb_grn_node_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reset_nos;
    logic       init_state;
    logic [1:0] start;
    logic [7:0] div;
    logic [3:0] din;
    logic [1:0] s;
    logic [1:0] upd;
    logic [1:0] chg;
`ifdef GRN_NODE_TCNT_EN
    logic [3:0] tcnt;
    logic [7:0] m_tcnt;
`endif

    logic       m_rnos;
    logic       m_start;
    logic [3:0] m_div;
    logic [2:0] m_din;
    logic       m_s;
    logic       m_upd;
    logic       m_chg;

    always #5 clk = ~clk;

    grn_node_multi #(.NCH(2), .NIN(2), .DIV_W(4), .FUNC(0), .CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reset_nos  (reset_nos),
        .init_state (init_state),
        .start      (start),
        .div        (div),
        .din        (din),
        .s          (s),
        .upd        (upd),
        .chg        (chg)
`ifdef GRN_NODE_TCNT_EN
        ,
        .tcnt       (tcnt)
`endif
    );

    grn_node_multi #(.NCH(1), .NIN(3), .DIV_W(4), .FUNC(2), .CNT_W(8)) dut_maj (
        .clk        (clk),
        .rst_n      (rst_n),
        .reset_nos  (m_rnos),
        .init_state (1'b0),
        .start      (m_start),
        .div        (m_div),
        .din        (m_din),
        .s          (m_s),
        .upd        (m_upd),
        .chg        (m_chg)
`ifdef GRN_NODE_TCNT_EN
        ,
        .tcnt       (m_tcnt)
`endif
    );

    typedef struct {
        string      tag;
        logic [1:0] s;
        logic [1:0] upd;
        logic [1:0] chg;
    } exp_t;

    exp_t q[$];
    exp_t mq[$];
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are set by the caller just after a falling edge; expectation is queued,
    // the rising edge applies it, and the result is popped and compared after it.
    task automatic step(input string tag, input logic [1:0] es, input logic [1:0] eu,
                        input logic [1:0] ec);
        exp_t e;
        q.push_back('{tag, es, eu, ec});
        @(posedge clk);
        #1;
        start     = 2'b00;
        reset_nos = 1'b0;
        e = q.pop_front();
        chk({e.tag, "_s"},   {6'd0, s},   {6'd0, e.s});
        chk({e.tag, "_upd"}, {6'd0, upd}, {6'd0, e.upd});
        chk({e.tag, "_chg"}, {6'd0, chg}, {6'd0, e.chg});
        @(negedge clk);
    endtask

    task automatic mstep(input string tag, input logic es, input logic eu, input logic ec);
        exp_t e;
        mq.push_back('{tag, {1'b0, es}, {1'b0, eu}, {1'b0, ec}});
        @(posedge clk);
        #1;
        m_start = 1'b0;
        m_rnos  = 1'b0;
        e = mq.pop_front();
        chk({e.tag, "_s"},   {7'd0, m_s},   {6'd0, e.s});
        chk({e.tag, "_upd"}, {7'd0, m_upd}, {6'd0, e.upd});
        chk({e.tag, "_chg"}, {7'd0, m_chg}, {6'd0, e.chg});
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        reset_nos  = 1'b0;
        init_state = 1'b0;
        start      = 2'b00;
        div        = 8'h00;
        din        = 4'b0000;
        m_rnos     = 1'b0;
        m_start    = 1'b0;
        m_div      = 4'h0;
        m_din      = 3'b000;
        repeat (2) @(negedge clk);
        chk("rst_s",   {6'd0, s},   8'h00);
        chk("rst_upd", {6'd0, upd}, 8'h00);
        chk("rst_chg", {6'd0, chg}, 8'h00);
`ifdef GRN_NODE_TCNT_EN
        chk("rst_tcnt", {4'd0, tcnt}, 8'h00);
`endif

        // First start after reset is a skip, second one updates.
        rst_n = 1'b1;
        div   = 8'h00;
        din   = 4'b0011;
        start = 2'b01; step("rst_skip",   2'b00, 2'b00, 2'b00);
        start = 2'b01; step("rst_second", 2'b01, 2'b01, 2'b01);
        step("idle", 2'b01, 2'b00, 2'b00);

        init_state = 1'b1; reset_nos = 1'b1; step("nos_init1", 2'b11, 2'b11, 2'b00);
        din = 4'b0000; start = 2'b01; step("or_zero", 2'b10, 2'b01, 2'b01);

        // Divide-by-2 on channel 1: update, skip, update, skip.
        init_state = 1'b0; reset_nos = 1'b1; step("nos_init0", 2'b00, 2'b11, 2'b00);
        div = 8'h10;
        din = 4'b0100;
        start = 2'b10; step("div1_a", 2'b10, 2'b10, 2'b10);
        start = 2'b10; step("div1_b", 2'b10, 2'b00, 2'b00);
        start = 2'b10; step("div1_c", 2'b10, 2'b10, 2'b00);
        start = 2'b10; step("div1_d", 2'b10, 2'b00, 2'b00);

        // reset_nos beats a simultaneous start and leaves ph at 0.
        din = 4'b0011; reset_nos = 1'b1; start = 2'b01;
        step("nos_wins", 2'b00, 2'b11, 2'b00);
        start = 2'b01; step("after_nos", 2'b01, 2'b01, 2'b01);
        din = 4'b0000; start = 2'b11; step("both_ch", 2'b00, 2'b11, 2'b01);

        // Async reset in the middle of a countdown leaves no pulse behind.
        div = 8'h13;
        din = 4'b0011;
        start = 2'b01; step("cd_load", 2'b01, 2'b01, 2'b01);
        start = 2'b01; step("cd_skip", 2'b01, 2'b00, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        chk("async_s",   {6'd0, s},   8'h00);
        chk("async_upd", {6'd0, upd}, 8'h00);
        chk("async_chg", {6'd0, chg}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        start = 2'b01; step("post_rst_skip", 2'b00, 2'b00, 2'b00);

        // Five toggles on channel 0.
        reset_nos = 1'b1; step("nos_t", 2'b00, 2'b11, 2'b00);
`ifdef GRN_NODE_TCNT_EN
        chk("tcnt_clr0", {4'd0, tcnt}, 8'h00);
`endif
        div = 8'h00;
        din = 4'b0011; start = 2'b01; step("tg1", 2'b01, 2'b01, 2'b01);
        din = 4'b0000; start = 2'b01; step("tg2", 2'b00, 2'b01, 2'b01);
        din = 4'b0011; start = 2'b01; step("tg3", 2'b01, 2'b01, 2'b01);
        din = 4'b0000; start = 2'b01; step("tg4", 2'b00, 2'b01, 2'b01);
        din = 4'b0011; start = 2'b01; step("tg5", 2'b01, 2'b01, 2'b01);
`ifdef GRN_NODE_TCNT_EN
        chk("tcnt_sat", {4'd0, tcnt}, 8'h03);
`endif
        reset_nos = 1'b1; step("nos_t2", 2'b00, 2'b11, 2'b00);
`ifdef GRN_NODE_TCNT_EN
        chk("tcnt_clr1", {4'd0, tcnt}, 8'h00);
`endif

        // Majority of three.
        m_rnos = 1'b1; mstep("maj_nos", 1'b0, 1'b1, 1'b0);
        m_din = 3'b011; m_start = 1'b1; mstep("maj_011", 1'b1, 1'b1, 1'b1);
        m_din = 3'b001; m_start = 1'b1; mstep("maj_001", 1'b0, 1'b1, 1'b1);
        m_din = 3'b111; m_start = 1'b1; mstep("maj_111", 1'b1, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
